// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for wide_add_sequencer: FSM encoding, legal width range
// and the byte-index width helper.
package wide_add_sequencer_pkg;

  localparam int BYTES_MIN = 2;
  localparam int BYTES_MAX = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of the byte index; never below one bit so the index always exists.
  function automatic int idx_width(input int bytes);
    return (bytes < 2) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// Legacy 8-bit ripple-carry adder (74283-pair equivalent) shared by the
// wide_add_sequencer. DELAY_RISE/DELAY_FALL annotate the gate model only.
module adder #(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [8:0] carry;

  // Delays are timing annotations of the original part and carry no logic.
  if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
    $error("adder: DELAY_RISE and DELAY_FALL must be non-negative");
  end

  assign carry[0] = c_in;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[8];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-byte add/subtract sequencer: one shared 8-bit adder, one byte per
// clock, LSB first. Define WIDE_ADD_SUB_EN to add the OP_SUB subtract mode.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int BYTES      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
`ifdef WIDE_ADD_SUB_EN
  input  logic               OP_SUB,
`endif
  input  logic               CARRY_IN,
  input  logic [8*BYTES-1:0] LHS,
  input  logic [8*BYTES-1:0] RHS,
  output logic               BUSY,
  output logic               DONE,
  output logic [8*BYTES-1:0] RESULT,
  output logic               CARRY_OUT,
  output logic               ZERO,
  output logic [1:0]         dbg_state
);

  localparam int W  = 8 * BYTES;
  localparam int IW = idx_width(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  if ((BYTES < BYTES_MIN) || (BYTES > BYTES_MAX)) begin : g_bad_bytes
    $error("wide_add_sequencer: BYTES out of range 2..8");
  end

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  lhs_q;
  logic [W-1:0]  rhs_q;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic          carry_out_q;
  logic          zero_q;
  logic          busy_q;
  logic          done_q;
  logic          sub_in;
  logic          sub_q;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    sum_byte;
  logic          c_out;
  logic [W-1:0]  result_next;

`ifdef WIDE_ADD_SUB_EN
  assign sub_in = OP_SUB;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sub_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && START) begin
      sub_q <= OP_SUB;
    end
  end
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  // Subtract is add of the inverted RHS with an inverted carry-in.
  assign a_byte = lhs_q[8*idx_q +: 8];
  assign b_byte = rhs_q[8*idx_q +: 8] ^ {8{sub_q}};

  adder #(
    .DELAY_RISE(DELAY_RISE),
    .DELAY_FALL(DELAY_FALL)
  ) u_adder (
    .a    (a_byte),
    .b    (b_byte),
    .c_in (carry_q),
    .sum  (sum_byte),
    .c_out(c_out)
  );

  // Result with the current byte merged in, so ZERO sees the full word.
  always_comb begin
    result_next = result_q;
    result_next[8*idx_q +: 8] = sum_byte;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      lhs_q       <= '0;
      rhs_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            lhs_q       <= LHS;
            rhs_q       <= RHS;
            carry_q     <= CARRY_IN ^ sub_in;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          result_q <= result_next;
          carry_q  <= c_out;
          if (idx_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            idx_q       <= '0;
            carry_out_q <= c_out ^ sub_q;
            zero_q      <= (result_next == '0);
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign CARRY_OUT = carry_out_q;
  assign ZERO      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (BYTES=4): directed scenarios
// plus randomized operations against a cycle-count behavioural model.
module tb_wide_add_sequencer;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         CLK;
  logic         RESET_N;
  logic         START;
  logic         OP_SUB;
  logic         CARRY_IN;
  logic [W-1:0] LHS;
  logic [W-1:0] RHS;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         CARRY_OUT;
  logic         ZERO;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(
    .BYTES(BYTES),
    .DELAY_RISE(0),
    .DELAY_FALL(0)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
`ifdef WIDE_ADD_SUB_EN
    .OP_SUB   (OP_SUB),
`endif
    .CARRY_IN (CARRY_IN),
    .LHS      (LHS),
    .RHS      (RHS),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .CARRY_OUT(CARRY_OUT),
    .ZERO     (ZERO),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: cycles since accepted START, and the final answer
  int           m_cnt = 0;
  logic [W-1:0] f_res = '0;
  logic         f_cout = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0;
  logic         m_zero = 1'b0;

  function automatic logic [W:0] model_op(input logic [W-1:0] l, input logic [W-1:0] r,
                                          input logic cin, input logic sub);
    logic [W:0] full;
    if (sub) begin
      full[W-1:0] = l - r - W'(cin);
      full[W]     = ({1'b0, l} < ({1'b0, r} + (W+1)'(cin)));
    end else begin
      full = {1'b0, l} + {1'b0, r} + (W+1)'(cin);
    end
    return full;
  endfunction

  always @(posedge CLK) begin
    logic [W:0]   op;
    logic [63:0]  mask;
    logic [W-1:0] shown;
    if (!RESET_N) begin
      m_cnt = 0; m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
    end else if (m_cnt == 0) begin
      if (START) begin
        op     = model_op(LHS, RHS, CARRY_IN, OP_SUB);
        f_res  = op[W-1:0];
        f_cout = op[W];
        m_cnt  = 1;
        m_res  = '0; m_cout = 1'b0; m_zero = 1'b0;
      end
    end else if (m_cnt <= BYTES) begin
      m_cnt++;
      if (m_cnt == BYTES + 1) begin
        m_res  = f_res;
        m_cout = f_cout;
        m_zero = (f_res == '0);
      end
    end else begin
      m_cnt = 0;
    end
    #1;
    if (m_cnt >= 1 && m_cnt <= BYTES) begin
      mask  = (64'd1 << (8 * (m_cnt - 1))) - 64'd1;
      shown = f_res & mask[W-1:0];
    end else begin
      shown = m_res;
    end
    chk("busy", 64'(BUSY), 64'(m_cnt >= 1 && m_cnt <= BYTES));
    chk("done", 64'(DONE), 64'(m_cnt == BYTES + 1));
    chk("result", 64'(RESULT), 64'(shown));
    if (m_cnt == 0 || m_cnt == BYTES + 1) begin
      chk("carry_out", 64'(CARRY_OUT), 64'(m_cout));
      chk("zero", 64'(ZERO), 64'(m_zero));
    end
  end

  // driver tasks
  task automatic wait_done(output int lat);
    lat = 1;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic cin, input logic sub, output int lat);
    @(negedge CLK);
    LHS = l; RHS = r; CARRY_IN = cin; OP_SUB = sub; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(lat);
    chk("latency", 64'(lat), 64'(BYTES + 1));
  endtask

  task automatic to_idle();
    @(negedge CLK);
  endtask

  initial begin
    int lat;
    logic [W-1:0] l, r;
    RESET_N = 1'b0; START = 1'b0; OP_SUB = 1'b0; CARRY_IN = 1'b0;
    LHS = '0; RHS = '0;
    #13;
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_result", 64'(RESULT), 64'd0);
    chk("reset_cout", 64'(CARRY_OUT), 64'd0);
    chk("reset_zero", 64'(ZERO), 64'd0);
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;

    // basic add
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("basic_result", 64'(RESULT), 64'h100);
    chk("basic_cout", 64'(CARRY_OUT), 64'd0);
    chk("basic_zero", 64'(ZERO), 64'd0);
    to_idle();
    chk("hold_result", 64'(RESULT), 64'h100);

    // wrap-around
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat);
    chk("wrap_result", 64'(RESULT), 64'd0);
    chk("wrap_cout", 64'(CARRY_OUT), 64'd1);
    chk("wrap_zero", 64'(ZERO), 64'd1);
    to_idle();

    // START held through RUN/DONE, operands changed mid-RUN
    @(negedge CLK);
    LHS = 32'h0000_0010; RHS = 32'h0000_0020; CARRY_IN = 1'b0; START = 1'b1;
    @(negedge CLK); @(negedge CLK);
    LHS = 32'hAAAA_0000;
    lat = 2;
    while (!DONE && lat < 20) begin @(negedge CLK); lat++; end
    chk("held_latency", 64'(lat), 64'(BYTES + 1));
    chk("held_result", 64'(RESULT), 64'h30);
    @(negedge CLK);
    chk("held_idle_busy", 64'(BUSY), 64'd0);
    LHS = 32'h0000_0005; RHS = 32'h0000_0006;
    @(negedge CLK);
    START = 1'b0;
    chk("next_busy", 64'(BUSY), 64'd1);
    wait_done(lat);
    chk("next_latency", 64'(lat), 64'(BYTES + 1));
    chk("next_result", 64'(RESULT), 64'd11);
    to_idle();

    // reset in the third RUN cycle
    @(negedge CLK);
    LHS = 32'h1111_1111; RHS = 32'h0000_0001; CARRY_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_done", 64'(DONE), 64'd0);
    chk("midrst_result", 64'(RESULT), 64'd0);
    chk("midrst_cout", 64'(CARRY_OUT), 64'd0);
    chk("midrst_zero", 64'(ZERO), 64'd0);
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    do_op(32'h1, 32'h2, 1'b0, 1'b0, lat);
    chk("after_rst_result", 64'(RESULT), 64'd3);
    to_idle();

`ifdef WIDE_ADD_SUB_EN
    do_op(32'h0, 32'h1, 1'b0, 1'b1, lat);
    chk("sub_result", 64'(RESULT), 64'hFFFF_FFFF);
    chk("sub_borrow", 64'(CARRY_OUT), 64'd1);
    to_idle();
`endif

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: l = '0;
        1: l = '1;
        default: l = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = '1;
        default: r = $urandom;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge CLK);
`ifdef WIDE_ADD_SUB_EN
      do_op(l, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat);
`else
      do_op(l, r, 1'($urandom_range(0, 1)), 1'b0, lat);
`endif
      to_idle();
    end

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
